// File: rtl/auth_pkg.sv
// ---------------------------------------------------------------------------
// auth_pkg
//   Shared definitions for the PIN authentication engine: request op codes,
//   response status codes, FSM state encoding and the power-on account table.
//   The default table is exposed as functions of the entry index so that the
//   database can load it from inside a reset loop.
// ---------------------------------------------------------------------------
package auth_pkg;

    typedef enum logic [1:0] {
        OP_AUTH       = 2'd0,
        OP_CHANGE_PIN = 2'd1,
        OP_UNLOCK     = 2'd2,
        OP_RSVD       = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_NOT_FOUND = 3'd1,
        ST_BAD_PIN   = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_SAME_PIN  = 3'd4
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_CHECK,
        S_RESP
    } state_e;

    // Default account number for entry i: accounts 1..10, zero beyond.
    function automatic int unsigned default_acc(input int unsigned i);
        return (i < 10) ? i + 1 : 0;
    endfunction

    // Default PIN for entry i (decimal value held in binary), zero beyond.
    function automatic int unsigned default_pin(input int unsigned i);
        case (i)
            0:       return 1234;
            1:       return 2345;
            2:       return 3456;
            3:       return 4567;
            4:       return 5678;
            5:       return 6789;
            6:       return 7890;
            7:       return 8901;
            8:       return 9012;
            9:       return 7123;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/auth_db.sv
// ---------------------------------------------------------------------------
// auth_db
//   Account database: account numbers, PINs and failed-attempt counters.
//   All three arrays load the default table on reset. One combinational read
//   port and one write port share the same index.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   idx           entry index for both read and write
//   acc, pin, cnt read data at idx (zero when idx is out of range)
//   pin_we/wr_pin PIN write at the next rising edge
//   cnt_we/wr_cnt failed-attempt counter write at the next rising edge
// ---------------------------------------------------------------------------
module auth_db
    import auth_pkg::*;
#(
    parameter int NUM_ACC = 10,
    parameter int ACC_W   = 4,
    parameter int PIN_W   = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    output logic [ACC_W-1:0] acc,
    output logic [PIN_W-1:0] pin,
    output logic [CNT_W-1:0] cnt,
    input  logic             pin_we,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic             cnt_we,
    input  logic [CNT_W-1:0] wr_cnt
);

    logic [ACC_W-1:0] acc_mem [NUM_ACC];
    logic [PIN_W-1:0] pin_mem [NUM_ACC];
    logic [CNT_W-1:0] cnt_mem [NUM_ACC];

    // NOTE: the arrays are reset on purpose -- the database must reload its
    // default contents on every reset, so they are flops rather than a RAM.
    // Account numbers are only ever loaded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_mem[i] <= ACC_W'(default_acc(i));
                pin_mem[i] <= PIN_W'(default_pin(i));
                cnt_mem[i] <= '0;
            end
        end else if (int'(idx) < NUM_ACC) begin
            if (pin_we) pin_mem[idx] <= wr_pin;
            if (cnt_we) cnt_mem[idx] <= wr_cnt;
        end
    end

    always_comb begin
        acc = '0;
        pin = '0;
        cnt = '0;
        if (int'(idx) < NUM_ACC) begin
            acc = acc_mem[idx];
            pin = pin_mem[idx];
            cnt = cnt_mem[idx];
        end
    end

endmodule

// File: rtl/pin_auth_engine.sv
// ---------------------------------------------------------------------------
// pin_auth_engine
//   Sequential account/PIN checker. Accepts AUTH, CHANGE_PIN and UNLOCK
//   requests on a valid/ready port, scans the database one entry per cycle,
//   applies the lockout rules and answers with a one-cycle response strobe.
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only when idle)
//   req_op, req_acc, req_pin,    request fields, latched at accept
//   req_new_pin
//   resp_valid                   one-cycle response strobe
//   resp_status, resp_index,     registered response; hold between strobes
//   resp_tries
// ---------------------------------------------------------------------------
module pin_auth_engine
    import auth_pkg::*;
#(
    parameter int  NUM_ACC   = 10,
    parameter int  ACC_W     = 4,
    parameter int  PIN_W     = 16,
    parameter int  MAX_TRIES = 3,
    localparam int IDX_W     = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [ACC_W-1:0] req_acc,
    input  logic [PIN_W-1:0] req_pin,
    input  logic [PIN_W-1:0] req_new_pin,
    output logic             resp_valid,
    output logic [2:0]       resp_status,
    output logic [IDX_W-1:0] resp_index,
    output logic [1:0]       resp_tries
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [ACC_W-1:0] acc_q;
    logic [PIN_W-1:0] pin_q, new_pin_q;
    logic [IDX_W-1:0] scan_idx, hit_idx, rd_idx;
    logic             found_q;

    logic [ACC_W-1:0] db_acc;
    logic [PIN_W-1:0] db_pin;
    logic [CNT_W-1:0] db_cnt, wr_cnt;
    logic             pin_we, cnt_we;

    status_e          status_d;
    logic [IDX_W-1:0] index_d;
    logic [1:0]       tries_d;

    logic accept, hit, last;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid & req_ready;
    // Account 0 is the empty-slot marker and must never match.
    assign hit       = (acc_q != '0) && (db_acc == acc_q);
    assign last      = (scan_idx == IDX_W'(NUM_ACC - 1));
    // The read port follows the scan, then stays on the matched entry for CHECK.
    assign rd_idx    = (state_q == S_CHECK) ? hit_idx : scan_idx;

    auth_db #(
        .NUM_ACC (NUM_ACC),
        .ACC_W   (ACC_W),
        .PIN_W   (PIN_W),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_db (
        .clk    (clk),
        .rst    (rst),
        .idx    (rd_idx),
        .acc    (db_acc),
        .pin    (db_pin),
        .cnt    (db_cnt),
        .pin_we (pin_we),
        .wr_pin (new_pin_q),
        .cnt_we (cnt_we),
        .wr_cnt (wr_cnt)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Request latch and scan pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_AUTH;
            acc_q     <= '0;
            pin_q     <= '0;
            new_pin_q <= '0;
            scan_idx  <= '0;
            hit_idx   <= '0;
            found_q   <= 1'b0;
        end else if (accept) begin
            op_q      <= op_e'(req_op);
            acc_q     <= req_acc;
            pin_q     <= req_pin;
            new_pin_q <= req_new_pin;
            scan_idx  <= '0;
            found_q   <= 1'b0;
        end else if (state_q == S_SCAN) begin
            if (hit) begin
                hit_idx <= scan_idx;
                found_q <= 1'b1;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pin_we   = 1'b0;
        cnt_we   = 1'b0;
        wr_cnt   = '0;
        status_d = ST_NOT_FOUND;
        index_d  = '0;
        tries_d  = '0;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SCAN;
            S_SCAN:  if (hit || last) state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_RESP;
                // Reserved op and unknown account both answer NOT_FOUND, tries 0.
                if (found_q && op_q != OP_RSVD) begin
                    index_d = hit_idx;
                    tries_d = 2'(MAX_TRIES - int'(db_cnt));
                    if (op_q == OP_UNLOCK) begin
                        cnt_we   = 1'b1;
                        status_d = ST_OK;
                        tries_d  = 2'(MAX_TRIES);
                    end else if (db_cnt == CNT_W'(MAX_TRIES)) begin
                        // Locked: no PIN compare, nothing changes.
                        status_d = ST_LOCKED;
                    end else if (db_pin != pin_q) begin
                        // db_cnt < MAX_TRIES here, so the increment saturates.
                        cnt_we   = 1'b1;
                        wr_cnt   = db_cnt + CNT_W'(1);
                        status_d = ST_BAD_PIN;
                        tries_d  = 2'(MAX_TRIES - int'(db_cnt) - 1);
                    end else begin
                        cnt_we  = 1'b1;
                        tries_d = 2'(MAX_TRIES);
                        if (op_q == OP_CHANGE_PIN && new_pin_q == db_pin) begin
                            status_d = ST_SAME_PIN;
                        end else begin
                            pin_we   = (op_q == OP_CHANGE_PIN);
                            status_d = ST_OK;
                        end
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response registers load on the CHECK->RESP edge and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_status <= '0;
            resp_index  <= '0;
            resp_tries  <= '0;
        end else begin
            resp_valid <= (state_q == S_CHECK);
            if (state_q == S_CHECK) begin
                resp_status <= status_d;
                resp_index  <= index_d;
                resp_tries  <= tries_d;
            end
        end
    end

endmodule

// File: tb/tb_pin_auth_engine.sv
// ---------------------------------------------------------------------------
// tb_pin_auth_engine
//   Directed vector table for the documented scenarios, a reset-abort
//   sequence, then randomized requests checked against a behavioural model
//   of the account database.
// ---------------------------------------------------------------------------
module tb_pin_auth_engine;

    localparam int NUM_ACC = 10;
    localparam int IDX_W   = $clog2(NUM_ACC);
    localparam int MAXT    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [3:0]       req_acc;
    logic [15:0]      req_pin;
    logic [15:0]      req_new_pin;
    logic             resp_valid;
    logic [2:0]       resp_status;
    logic [IDX_W-1:0] resp_index;
    logic [1:0]       resp_tries;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pin_auth_engine dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_acc     (req_acc),
        .req_pin     (req_pin),
        .req_new_pin (req_new_pin),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .resp_index  (resp_index),
        .resp_tries  (resp_tries)
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] npin;
        logic [2:0]  st;
        logic [3:0]  ix;
        logic [1:0]  tr;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model of the database.
    int unsigned def_pin [NUM_ACC] = '{1234, 2345, 3456, 4567, 5678,
                                       6789, 7890, 8901, 9012, 7123};
    int unsigned m_acc  [NUM_ACC];
    int unsigned m_pin  [NUM_ACC];
    int          m_fail [NUM_ACC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_ACC; i++) begin
            m_acc[i]  = i + 1;
            m_pin[i]  = def_pin[i];
            m_fail[i] = 0;
        end
    endfunction

    // Fills in the expected response and updates the model state.
    function automatic vec_t model_req(input vec_t v);
        vec_t r;
        int   k;
        r = v;
        k = -1;
        if (v.acc != 0)
            for (int i = 0; i < NUM_ACC; i++)
                if (k < 0 && m_acc[i] == v.acc) k = i;
        r.lat = (k < 0) ? NUM_ACC + 1 : k + 2;
        if (k < 0 || v.op == 2'd3) begin
            r.st = 3'd1; r.ix = 4'd0; r.tr = 2'd0;
        end else begin
            r.ix = 4'(k);
            if (v.op == 2'd2) begin
                m_fail[k] = 0; r.st = 3'd0;
            end else if (m_fail[k] == MAXT) begin
                r.st = 3'd3;
            end else if (v.pin != m_pin[k]) begin
                m_fail[k]++; r.st = 3'd2;
            end else begin
                m_fail[k] = 0;
                if (v.op == 2'd1 && v.npin == m_pin[k]) r.st = 3'd4;
                else begin
                    if (v.op == 2'd1) m_pin[k] = v.npin;
                    r.st = 3'd0;
                end
            end
            r.tr = 2'(MAXT - m_fail[k]);
        end
        return r;
    endfunction

    function automatic void add(input logic [1:0] op, input logic [3:0] acc,
                                input logic [15:0] pin, input logic [15:0] npin,
                                input logic [2:0] st, input logic [3:0] ix,
                                input logic [1:0] tr, input int lat);
        vec_t v;
        v.op = op; v.acc = acc; v.pin = pin; v.npin = npin;
        v.st = st; v.ix = ix; v.tr = tr; v.lat = lat;
        tbl.push_back(v);
    endfunction

    // One complete request with all response checks; inputs are driven #1
    // after a rising edge, outputs sampled #1 after a rising edge.
    task automatic send(input vec_t v, input string tag);
        int guard;
        int lat;
        bit ready_low;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_op = v.op; req_acc = v.acc;
        req_pin = v.pin; req_new_pin = v.npin;
        @(posedge clk); #1;
        // Scramble the fields to prove they were latched at accept.
        req_valid = 1'b0; req_op = 2'($urandom); req_acc = 4'($urandom);
        req_pin = 16'($urandom); req_new_pin = 16'($urandom);
        lat = 0;
        ready_low = 1'b1;
        do begin
            if (req_ready !== 1'b0) ready_low = 1'b0;
            @(posedge clk); #1; lat++;
        end while (resp_valid !== 1'b1 && lat < 30);
        if (req_ready !== 1'b0) ready_low = 1'b0;
        check({tag, " resp_valid"}, resp_valid, 1);
        if (v.op != 2'd3) check({tag, " latency"}, lat, v.lat);
        check({tag, " status"}, resp_status, v.st);
        check({tag, " index"}, resp_index, v.ix);
        check({tag, " tries"}, resp_tries, v.tr);
        check({tag, " ready_low_busy"}, ready_low, 1);
        @(posedge clk); #1;
        check({tag, " strobe_width"}, resp_valid, 0);
        check({tag, " status_hold"}, resp_status, v.st);
        check({tag, " ready_idle"}, req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_acc = '0;
        req_pin = '0; req_new_pin = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_status", resp_status, 0);
        check("reset resp_index", resp_index, 0);
        check("reset resp_tries", resp_tries, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        model_reset();

        //   op     acc    pin       new       st    ix    tr    lat
        add(2'd0, 4'd3,  16'd3456, 16'd0,    3'd0, 4'd2, 2'd3, 4);
        add(2'd0, 4'd11, 16'd0,    16'd0,    3'd1, 4'd0, 2'd0, 11);
        add(2'd0, 4'd0,  16'd0,    16'd0,    3'd1, 4'd0, 2'd0, 11);
        add(2'd0, 4'd5,  16'd0,    16'd0,    3'd2, 4'd4, 2'd2, 6);
        add(2'd0, 4'd5,  16'd0,    16'd0,    3'd2, 4'd4, 2'd1, 6);
        add(2'd0, 4'd5,  16'd0,    16'd0,    3'd2, 4'd4, 2'd0, 6);
        add(2'd0, 4'd5,  16'd5678, 16'd0,    3'd3, 4'd4, 2'd0, 6);
        add(2'd2, 4'd5,  16'd0,    16'd0,    3'd0, 4'd4, 2'd3, 6);
        add(2'd0, 4'd5,  16'd5678, 16'd0,    3'd0, 4'd4, 2'd3, 6);
        add(2'd1, 4'd1,  16'd1234, 16'd1234, 3'd4, 4'd0, 2'd3, 2);
        add(2'd1, 4'd1,  16'd1234, 16'd4321, 3'd0, 4'd0, 2'd3, 2);
        add(2'd0, 4'd1,  16'd1234, 16'd0,    3'd2, 4'd0, 2'd2, 2);
        add(2'd0, 4'd1,  16'd4321, 16'd0,    3'd0, 4'd0, 2'd3, 2);
        add(2'd0, 4'd7,  16'd0,    16'd0,    3'd2, 4'd6, 2'd2, 8);
        add(2'd0, 4'd7,  16'd1,    16'd0,    3'd2, 4'd6, 2'd1, 8);
        add(2'd0, 4'd7,  16'd7890, 16'd0,    3'd0, 4'd6, 2'd3, 8);
        add(2'd3, 4'd2,  16'd2345, 16'd0,    3'd1, 4'd0, 2'd0, 3);
        add(2'd0, 4'd10, 16'd7123, 16'd0,    3'd0, 4'd9, 2'd3, 11);

        foreach (tbl[i]) begin
            void'(model_req(tbl[i]));
            send(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset during SCAN of an acc=9 request: no response, table reloaded.
        req_valid = 1'b1; req_op = 2'd0; req_acc = 4'd9;
        req_pin = 16'd9012; req_new_pin = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort req_ready", req_ready, 1);
        check("abort resp_valid", resp_valid, 0);
        @(negedge clk); rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            repeat (15) begin
                @(posedge clk); #1;
                if (resp_valid === 1'b1) seen = 1'b1;
            end
            check("abort no_response", seen, 0);
        end
        model_reset();
        begin
            vec_t v;
            v.op = 2'd0; v.acc = 4'd1; v.pin = 16'd1234; v.npin = 16'd0;
            v.st = 3'd0; v.ix = 4'd0; v.tr = 2'd3; v.lat = 2;
            void'(model_req(v));
            send(v, "reload");
        end

        for (int n = 0; n < 60; n++) begin
            vec_t v;
            int   r;
            r = $urandom_range(0, 9);
            v.op  = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            v.acc = 4'($urandom_range(0, 11));
            if (v.acc >= 1 && v.acc <= 10 && $urandom_range(0, 1) == 1)
                v.pin = 16'(m_pin[v.acc - 1]);
            else
                v.pin = 16'($urandom_range(0, 9999));
            v.npin = ($urandom_range(0, 3) == 0) ? v.pin : 16'($urandom_range(0, 9999));
            v = model_req(v);
            send(v, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
